alu_share_arbiter: RTL and testbench

//  Shares one combinational 16-bit ALU (m, n, 3-bit opcode, carry-in -> f, zero, negative)

---
 rtl/alu_share_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
    parameter int W       = 16,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*OPW-1:0] req_opc,
    input  logic [2*W-1:0]   req_m,
    input  logic [2*W-1:0]   req_n,
    input  logic [1:0]       req_c,
    output logic [OPW-1:0]   alu_opc,
    output logic [W-1:0]     alu_m,
    output logic [W-1:0]     alu_n,
    output logic             alu_c,
    input  logic [W-1:0]     alu_f,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_f,
    output logic             rsp_zer,
    output logic             rsp_neg,
    output logic             busy
);
    localparam int CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, state_nx;
    logic          rr;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic          accept;
    logic          accept_id;
    logic          cnt_done;

    assign accept    = |(req_valid & grant);
    assign accept_id = grant[1];
    assign cnt_done  = (cnt == CW'(1));
    assign req_ready = grant;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grants exist only in IDLE; rr names the requester favoured on a tie.
    always_comb begin
        state_nx = state;
        grant    = 2'b00;
        case (state)
            IDLE: begin
                case (req_valid)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    2'b11:   grant = rr ? 2'b10 : 2'b01;
                    default: grant = 2'b00;
                endcase
                if (|(req_valid & grant)) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (cnt_done) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= 1'b0;
            cnt       <= '0;
            alu_opc   <= '0;
            alu_m     <= '0;
            alu_n     <= '0;
            alu_c     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_f     <= '0;
            rsp_zer   <= 1'b0;
            rsp_neg   <= 1'b0;
        end else begin
            if (accept) begin
                alu_opc <= accept_id ? req_opc[2*OPW-1:OPW] : req_opc[OPW-1:0];
                alu_m   <= accept_id ? req_m[2*W-1:W] : req_m[W-1:0];
                alu_n   <= accept_id ? req_n[2*W-1:W] : req_n[W-1:0];
                alu_c   <= accept_id ? req_c[1] : req_c[0];
                rsp_id  <= accept_id;
                rr      <= ~accept_id;
                cnt     <= CW'(ALU_LAT);
            end
            // ALU outputs are sampled only on the last counted edge, so earlier glitches are ignored.
            if (state == EXEC) begin
                cnt <= cnt - CW'(1);
                if (cnt_done) begin
                    rsp_f     <= alu_f;
                    rsp_zer   <= alu_zer;
                    rsp_neg   <= alu_neg;
                    rsp_valid <= 1'b1;
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter (ALU_LAT=1 and ALU_LAT=3 instances)
module tb_alu_share_arbiter;
    localparam int W   = 16;
    localparam int OPW = 3;

    typedef struct packed {
        logic         id;
        logic [W-1:0] f;
        logic         zer;
        logic         neg;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_ready, req_valid_b, req_ready_b;
    logic [2*OPW-1:0] req_opc;
    logic [2*W-1:0]   req_m, req_n;
    logic [1:0]       req_c;
    logic [OPW-1:0]   alu_opc, alu_opc_b;
    logic [W-1:0]     alu_m, alu_n, alu_f, alu_m_b, alu_n_b, alu_f_b;
    logic             alu_c, alu_zer, alu_neg, alu_c_b, alu_zer_b, alu_neg_b;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zer, rsp_neg, busy;
    logic             rsp_valid_b, rsp_ready_b, rsp_id_b, rsp_zer_b, rsp_neg_b, busy_b;
    logic [W-1:0]     rsp_f, rsp_f_b;
    logic [W-1:0]     glitch;

    assign alu_f     = alu_m + alu_n + W'(alu_c);
    assign alu_zer   = (alu_f == '0);
    assign alu_neg   = alu_f[W-1];
    assign alu_f_b   = (alu_m_b + alu_n_b + W'(alu_c_b)) ^ glitch;
    assign alu_zer_b = (alu_f_b == '0);
    assign alu_neg_b = alu_f_b[W-1];

    alu_share_arbiter #(.W(W), .OPW(OPW), .ALU_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opc(req_opc), .req_m(req_m), .req_n(req_n), .req_c(req_c),
        .alu_opc(alu_opc), .alu_m(alu_m), .alu_n(alu_n), .alu_c(alu_c),
        .alu_f(alu_f), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_f(rsp_f), .rsp_zer(rsp_zer), .rsp_neg(rsp_neg), .busy(busy)
    );

    alu_share_arbiter #(.W(W), .OPW(OPW), .ALU_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_opc(req_opc), .req_m(req_m), .req_n(req_n), .req_c(req_c),
        .alu_opc(alu_opc_b), .alu_m(alu_m_b), .alu_n(alu_n_b), .alu_c(alu_c_b),
        .alu_f(alu_f_b), .alu_zer(alu_zer_b), .alu_neg(alu_neg_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b),
        .rsp_f(rsp_f_b), .rsp_zer(rsp_zer_b), .rsp_neg(rsp_neg_b), .busy(busy_b)
    );

    rsp_t exp_q[$];
    rsp_t exp_qb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_a(input logic id, input logic [W-1:0] f, input logic z, input logic n);
        rsp_t e;
        e.id = id; e.f = f; e.zer = z; e.neg = n;
        exp_q.push_back(e);
    endtask

    task automatic expect_b(input logic id, input logic [W-1:0] f, input logic z, input logic n);
        rsp_t e;
        e.id = id; e.f = f; e.zer = z; e.neg = n;
        exp_qb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [OPW-1:0] opc, input logic [W-1:0] m,
                           input logic [W-1:0] n, input logic c);
        req_opc[i*OPW +: OPW] = opc;
        req_m[i*W +: W]       = m;
        req_n[i*W +: W]       = n;
        req_c[i]              = c;
    endtask

    // Waits for the grant on dut_a, checks which requester won, and drops that request after the edge.
    task automatic wait_grant(input string name, input logic [1:0] exp);
        logic [1:0] g;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            if (g != 2'b00) begin
                seen = 1'b1;
                check(name, 32'(req_ready), 32'(exp));
                @(posedge clk);
                #1 req_valid = req_valid & ~g;
            end
        end
        if (!seen) begin
            vectors++;
            errors++;
            $display("FAIL %s: got no grant within 20 cycles, expected %0h", name, exp);
        end
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (exp_qb.size() == 0) && !busy && !busy_b;
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL %s_drain: got %0d+%0d pending responses, expected 0", name, exp_q.size(), exp_qb.size());
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        rsp_t e;
        rsp_t got;
        if (!rst && rsp_valid && rsp_ready) begin
            vectors++;
            got = {rsp_id, rsp_f, rsp_zer, rsp_neg};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_a_unexpected: got id=%0d f=%h, expected no response", rsp_id, rsp_f);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL rsp_a: got id=%0d f=%h z=%0d n=%0d, expected id=%0d f=%h z=%0d n=%0d",
                             got.id, got.f, got.zer, got.neg, e.id, e.f, e.zer, e.neg);
                end
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        rsp_t got;
        if (!rst && rsp_valid_b && rsp_ready_b) begin
            vectors++;
            got = {rsp_id_b, rsp_f_b, rsp_zer_b, rsp_neg_b};
            if (exp_qb.size() == 0) begin
                errors++;
                $display("FAIL rsp_b_unexpected: got id=%0d f=%h, expected no response", rsp_id_b, rsp_f_b);
            end else begin
                e = exp_qb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL rsp_b: got id=%0d f=%h z=%0d n=%0d, expected id=%0d f=%h z=%0d n=%0d",
                             got.id, got.f, got.zer, got.neg, e.id, e.f, e.zer, e.neg);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 time units, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] g;
        int last;
        int ng;
        rst = 1'b1; req_valid = 2'b00; req_valid_b = 2'b00;
        req_opc = '0; req_m = '0; req_n = '0; req_c = '0;
        rsp_ready = 1'b1; rsp_ready_b = 1'b1; glitch = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_alu_m", 32'(alu_m), 32'd0);
        check("rst_alu_opc", 32'(alu_opc), 32'd0);
        check("rst_rsp_f", 32'(rsp_f), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        @(posedge clk);
        #1;

        // single requester, exact latency
        set_req(0, 3'd3, 16'h0003, 16'h0004, 1'b1);
        req_valid = 2'b01;
        expect_a(1'b0, 16'h0008, 1'b0, 1'b0);
        wait_grant("t1_grant", 2'b01);
        @(negedge clk);
        check("t1_alu_m", 32'(alu_m), 32'h3);
        check("t1_alu_opc", 32'(alu_opc), 32'h3);
        check("t1_alu_c", 32'(alu_c), 32'h1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_rsp_valid_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        drain("t1");

        // flag boundaries
        set_req(0, 3'd0, 16'h8000, 16'h8000, 1'b0);
        req_valid = 2'b01;
        expect_a(1'b0, 16'h0000, 1'b1, 1'b0);
        wait_grant("t4a_grant", 2'b01);
        drain("t4a");
        set_req(1, 3'd5, 16'hFFFF, 16'h0000, 1'b0);
        req_valid = 2'b10;
        expect_a(1'b1, 16'hFFFF, 1'b0, 1'b1);
        wait_grant("t4b_grant", 2'b10);
        drain("t4b");

        // both valid continuously after reset: alternation and 3-cycle spacing
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        set_req(0, 3'd1, 16'h0010, 16'h0020, 1'b0);
        set_req(1, 3'd2, 16'h7FFF, 16'h0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) expect_a(1'b0, 16'h0030, 1'b0, 1'b0);
            else            expect_a(1'b1, 16'h8000, 1'b0, 1'b1);
        end
        req_valid = 2'b11;
        last = -1;
        ng = 0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            if (g != 2'b00) begin
                check($sformatf("t2_grant%0d", ng), 32'(req_ready), (ng % 2 == 0) ? 32'h1 : 32'h2);
                if (ng > 0) check($sformatf("t2_spacing%0d", ng), 32'(cyc - last), 32'd3);
                last = cyc;
                ng++;
            end
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        check("t2_grant_count", 32'(ng), 32'd4);
        drain("t2");

        // consumer stall in RESP
        rsp_ready = 1'b0;
        set_req(1, 3'd1, 16'h1234, 16'h0001, 1'b0);
        req_valid = 2'b10;
        expect_a(1'b1, 16'h1235, 1'b0, 1'b0);
        wait_grant("t3_grant_r1", 2'b10);
        set_req(0, 3'd2, 16'h0005, 16'hFFFB, 1'b0);
        req_valid = 2'b01;
        expect_a(1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_exec_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t3_valid%0d", k), 32'(rsp_valid), 32'd1);
            check($sformatf("t3_f%0d", k), 32'(rsp_f), 32'h1235);
            check($sformatf("t3_id%0d", k), 32'(rsp_id), 32'd1);
            check($sformatf("t3_ready%0d", k), 32'(req_ready), 32'd0);
            check($sformatf("t3_busy%0d", k), 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_idle_valid", 32'(rsp_valid), 32'd0);
        check("t3_idle_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        drain("t3");

        // reset while executing with both requests pending
        set_req(0, 3'd4, 16'h00FF, 16'h0001, 1'b0);
        set_req(1, 3'd6, 16'h0AAA, 16'h0555, 1'b0);
        req_valid = 2'b01;
        wait_grant("t5_pre_grant", 2'b01);
        req_valid = 2'b11;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_alu_m", 32'(alu_m), 32'd0);
        check("t5_grant_r0", 32'(req_ready), 32'h1);
        expect_a(1'b0, 16'h0100, 1'b0, 1'b0);
        @(posedge clk);
        #1 req_valid = 2'b00;
        drain("t5");

        // ALU_LAT=3: capture on the third edge only
        set_req(0, 3'd7, 16'h0100, 16'h0200, 1'b1);
        req_valid_b = 2'b01;
        expect_b(1'b0, 16'h0301, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_grant", 32'(req_ready_b), 32'h1);
        @(posedge clk);
        #1 req_valid_b = 2'b00;
        @(negedge clk);
        check("t6_valid_e0", 32'(rsp_valid_b), 32'd0);
        @(posedge clk);
        #1 glitch = 16'hFFFF;
        @(negedge clk);
        check("t6_valid_e1", 32'(rsp_valid_b), 32'd0);
        @(posedge clk);
        #1 glitch = 16'h0000;
        @(negedge clk);
        check("t6_valid_e2", 32'(rsp_valid_b), 32'd0);
        @(negedge clk);
        check("t6_valid_e3", 32'(rsp_valid_b), 32'd1);
        check("t6_f_e3", 32'(rsp_f_b), 32'h0301);
        drain("t6");

        check("sb_a_empty", 32'(exp_q.size()), 32'd0);
        check("sb_b_empty", 32'(exp_qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
